fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 8-bit RISC pipeline.
- Holds the program counter and issues word requests to instruction memory over a req/ack handshake.
- Captures returned 16-bit instructions into the IF/ID register, which directly feeds the decoder (instruction, 3-bit opcode).
- Supports downstream stall via a one-entry skid buffer, and branch/jump redirect with flush.

Parameters:
PC_WIDTH, 8, width of program counter and instruction-memory word address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  PC_WIDTH  word address of request
imem_ack  input  1  memory returns imem_rdata this cycle; valid only while imem_req=1
imem_rdata  input  16  fetched instruction word
stall  input  1  downstream cannot accept; IF/ID must hold
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  PC_WIDTH  redirect target
instr_valid  output  1  IF/ID holds a valid instruction
instruction  output  16  IF/ID instruction to decoder
opcode  output  3  instruction[15:13], registered alongside instruction
instr_pc  output  PC_WIDTH  address of held instruction

Behaviour:
- One clock. Reset is asynchronous and active-low. All state is cleared on rst_n=0 regardless of clock.
- Reset values: pc=RESET_PC, state=ISSUE, instr_valid=0, instruction=0, opcode=0, instr_pc=0, skid empty.
- imem_req is combinational from state: 1 in ISSUE and FLUSH, 0 in FULL. imem_addr=pc.
- Protocol rule: imem_req and imem_addr stay stable from assertion until the imem_ack cycle.
- Consume condition: downstream consumes when instr_valid=1 and stall=0. IF/ID may load when instr_valid=0 or stall=0.
- ISSUE state:
  - ack and IF/ID may load: IF/ID<=rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1; stay ISSUE.
  - ack and IF/ID blocked: skid<=(rdata, pc), pc<=pc+1; go to FULL.
  - no ack: hold. If the IF/ID content is consumed, instr_valid<=0.
- FULL state (no request outstanding):
  - stall=0: IF/ID<=skid, skid emptied; go to ISSUE.
  - stall=1: hold.
- FLUSH state:
  - Keep the old request asserted; discard rdata on ack.
  - On ack, pc<=pending_pc and go to ISSUE.
  - A further redirect during FLUSH overwrites pending_pc.
- Redirect has priority over all other events, evaluated every cycle:
  - instr_valid<=0 and skid emptied.
  - ISSUE with ack this cycle (data discarded) or FULL: pc<=redirect_pc; go to ISSUE.
  - ISSUE without ack: pending_pc<=redirect_pc; go to FLUSH.
- Latency and throughput:
  - With same-cycle ack, an instruction appears on IF/ID the cycle after its request.
  - Sustained rate is one instruction per cycle.
  - After a redirect with same-cycle ack, the first target instruction is valid 2 cycles later.
- The stall/redirect interaction rule applies when both are asserted: redirect wins and the flush proceeds even while stalled.
- PC arithmetic is modulo 2^PC_WIDTH; 255+1 wraps to 0 for the default width.
- No instruction is ever duplicated or dropped except those flushed by redirect.

Test Plan:
- Reset then zero-wait memory returning rdata=16'h2000+addr → instr_pc 0,1,2… on consecutive cycles; instruction=16'h2000 gives opcode=3'b001; imem_addr starts at RESET_PC.
- Memory with 3-cycle ack latency → imem_req/imem_addr stable throughout the wait; instr_valid pulses once per 3 cycles.
- Stall held 4 cycles during a streaming fetch → IF/ID holds addr 5, addr 6 sits in skid, imem_req=0 in FULL; on release, addr 6 then 7 follow with no gap and no duplicate.
- redirect_valid with redirect_pc=8'h40 while a request is pending without ack → FLUSH; the old data is discarded on ack; the next request uses address 0x40; instr_valid=0 until the 0x40 instruction arrives.
- Redirect coinciding with ack and stall=1 → skid and IF/ID cleared; fetch resumes at the target.
- PC at 8'hFF fetched → next imem_addr=8'h00. Assert rst_n=0 mid-FLUSH → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, IF/ID register with
// a one-entry skid buffer for downstream stall, and redirect with flush.
module fetch_unit #(
  parameter int                    PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                instr_valid,
  output logic [15:0]         instruction,
  output logic [2:0]          opcode,
  output logic [PC_WIDTH-1:0] instr_pc
);

  typedef enum logic [1:0] {ISSUE, FULL, FLUSH} state_t;

  typedef struct packed {
    logic [15:0]         instr;
    logic [PC_WIDTH-1:0] pc;
  } ifid_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pending_pc;
  ifid_t               skid;
  logic                can_load;
  logic                consume;

  assign imem_req  = (state != FULL);
  assign imem_addr = pc;
  assign can_load  = !instr_valid || !stall;
  assign consume   = instr_valid && !stall;

  // The skid buffer is occupied exactly when state is FULL, so leaving FULL empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      pending_pc  <= '0;
      skid        <= '0;
      instr_valid <= 1'b0;
      instruction <= '0;
      opcode      <= '0;
      instr_pc    <= '0;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
      // With no request left in flight the target can be issued next cycle.
      if (state == FULL || imem_ack) begin
        pc    <= redirect_pc;
        state <= ISSUE;
      end else begin
        pending_pc <= redirect_pc;
        state      <= FLUSH;
      end
    end else begin
      case (state)
        ISSUE: begin
          if (imem_ack && can_load) begin
            instruction <= imem_rdata;
            opcode      <= imem_rdata[15:13];
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 1'b1;
          end else if (imem_ack) begin
            skid  <= '{instr: imem_rdata, pc: pc};
            pc    <= pc + 1'b1;
            state <= FULL;
          end else if (consume) begin
            instr_valid <= 1'b0;
          end
        end
        FULL: begin
          if (!stall) begin
            instruction <= skid.instr;
            opcode      <= skid.instr[15:13];
            instr_pc    <= skid.pc;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            pc    <= pending_pc;
            state <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// and a randomized run checked by a consumed-stream scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [2:0]  opcode;
  logic [7:0]  instr_pc;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instruction(instruction),
    .opcode(opcode), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // memory model state
  int   mem_lat = 0;
  bit   lat_rand = 0;
  int   cur_lat = 0;
  int   wcnt = 0;
  bit   data_mode = 0;

  // monitor / scoreboard state
  bit         mon_skip = 0;
  bit         p_req = 0;
  bit         p_ack = 0;
  logic [7:0] p_addr = '0;
  bit         sb_en = 0;
  logic [7:0] sb_exp = '0;
  int         n_cons = 0;

  typedef struct {
    logic       stall;
    logic       redir;
    logic [7:0] rpc;
    logic       e_valid;
    logic [7:0] e_ipc;
    logic       e_req;
    logic [7:0] e_addr;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [15:0] word(input logic [7:0] a);
    if (data_mode) return {a ^ 8'h5C, a};
    return 16'h2000 | {8'h00, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mem_drive();
    if (imem_req) begin
      if (wcnt == 0) cur_lat = lat_rand ? int'($urandom_range(0, 2)) : mem_lat;
      if (wcnt >= cur_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = word(imem_addr);
        wcnt       = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        wcnt++;
      end
    end else begin
      imem_ack = 1'b0;
    end
  endtask

  task automatic cyc(input logic s, input logic r, input logic [7:0] rp);
    stall = s;
    redirect_valid = r;
    redirect_pc = rp;
    mem_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string tag, input logic v, input logic [7:0] ipc,
                         input logic r, input logic [7:0] a);
    chk({tag, ".valid"}, instr_valid, v);
    chk({tag, ".req"}, imem_req, r);
    chk({tag, ".addr"}, imem_addr, a);
    if (v) begin
      chk({tag, ".ipc"}, instr_pc, ipc);
      chk({tag, ".instr"}, instruction, word(ipc));
      chk({tag, ".opcode"}, opcode, word(ipc) >> 13);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, instr_valid, 0);
    chk({tag, ".instr"}, instruction, 0);
    chk({tag, ".opcode"}, opcode, 0);
    chk({tag, ".ipc"}, instr_pc, 0);
    chk({tag, ".req"}, imem_req, 1);
    chk({tag, ".addr"}, imem_addr, 0);
  endtask

  // Reset is asserted between clock edges so its effect is purely asynchronous.
  task automatic do_reset(input bit check, input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    wcnt = 0;
    mon_skip = 1;
    #1;
    if (check) chk_reset(tag);
    #1;
    rst_n = 1'b1;
  endtask

  // Protocol hold check and consumed-stream scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      p_req = 0;
    end else begin
      if (mon_skip) mon_skip = 0;
      else if (p_req && !p_ack) begin
        chk("req_hold", imem_req, 1);
        chk("addr_hold", imem_addr, p_addr);
      end
      p_req  = imem_req;
      p_ack  = imem_ack;
      p_addr = imem_addr;
      if (sb_en) begin
        if (redirect_valid) sb_exp = redirect_pc;
        else if (instr_valid && !stall) begin
          chk("sb_pc", instr_pc, sb_exp);
          chk("sb_instr", instruction, word(sb_exp));
          chk("sb_opcode", opcode, word(sb_exp) >> 13);
          sb_exp = sb_exp + 8'd1;
          n_cons++;
        end
      end
    end
  end

  initial begin
    int pulses;

    // zero-wait stream, stall for 4 cycles at addr 5/6, release
    tbl = '{
      '{1'b0, 1'b0, 8'h00, 1'b1, 8'd0, 1'b1, 8'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 8'd1, 1'b1, 8'd2},
      '{1'b0, 1'b0, 8'h00, 1'b1, 8'd2, 1'b1, 8'd3},
      '{1'b0, 1'b0, 8'h00, 1'b1, 8'd3, 1'b1, 8'd4},
      '{1'b0, 1'b0, 8'h00, 1'b1, 8'd4, 1'b1, 8'd5},
      '{1'b0, 1'b0, 8'h00, 1'b1, 8'd5, 1'b1, 8'd6},
      '{1'b1, 1'b0, 8'h00, 1'b1, 8'd5, 1'b0, 8'd7},
      '{1'b1, 1'b0, 8'h00, 1'b1, 8'd5, 1'b0, 8'd7},
      '{1'b1, 1'b0, 8'h00, 1'b1, 8'd5, 1'b0, 8'd7},
      '{1'b1, 1'b0, 8'h00, 1'b1, 8'd5, 1'b0, 8'd7},
      '{1'b0, 1'b0, 8'h00, 1'b1, 8'd6, 1'b1, 8'd7},
      '{1'b0, 1'b0, 8'h00, 1'b1, 8'd7, 1'b1, 8'd8},
      '{1'b0, 1'b0, 8'h00, 1'b1, 8'd8, 1'b1, 8'd9}
    };

    data_mode = 0;
    mem_lat = 0;
    lat_rand = 0;
    do_reset(1, "reset");
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].stall, tbl[i].redir, tbl[i].rpc);
      exp_out($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_ipc, tbl[i].e_req, tbl[i].e_addr);
    end

    // 3-cycle ack latency: one valid pulse every third cycle
    mem_lat = 2;
    do_reset(0, "");
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      cyc(1'b0, 1'b0, 8'h00);
      chk($sformatf("lat3.valid%0d", k), instr_valid, (k % 3) == 2);
      if (instr_valid) begin
        chk("lat3.ipc", instr_pc, pulses);
        pulses++;
      end
    end
    chk("lat3.pulses", pulses, 3);

    // redirect while request pending without ack -> flush
    do_reset(0, "");
    cyc(1'b0, 1'b1, 8'h40); exp_out("fl0", 1'b0, 8'h00, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00); exp_out("fl1", 1'b0, 8'h00, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00); exp_out("fl2", 1'b0, 8'h00, 1'b1, 8'h40);
    cyc(1'b0, 1'b0, 8'h00); exp_out("fl3", 1'b0, 8'h00, 1'b1, 8'h40);
    cyc(1'b0, 1'b0, 8'h00); exp_out("fl4", 1'b0, 8'h00, 1'b1, 8'h40);
    cyc(1'b0, 1'b0, 8'h00); exp_out("fl5", 1'b1, 8'h40, 1'b1, 8'h41);

    // redirect with ack under stall, then redirect out of FULL under stall
    mem_lat = 0;
    do_reset(0, "");
    cyc(1'b0, 1'b0, 8'h00); exp_out("rs0", 1'b1, 8'h00, 1'b1, 8'h01);
    cyc(1'b1, 1'b1, 8'h80); exp_out("rs1", 1'b0, 8'h00, 1'b1, 8'h80);
    cyc(1'b1, 1'b0, 8'h00); exp_out("rs2", 1'b1, 8'h80, 1'b1, 8'h81);
    cyc(1'b0, 1'b0, 8'h00); exp_out("rs3", 1'b1, 8'h81, 1'b1, 8'h82);
    cyc(1'b1, 1'b0, 8'h00); exp_out("rs4", 1'b1, 8'h81, 1'b0, 8'h83);
    cyc(1'b1, 1'b1, 8'h10); exp_out("rs5", 1'b0, 8'h00, 1'b1, 8'h10);
    cyc(1'b0, 1'b0, 8'h00); exp_out("rs6", 1'b1, 8'h10, 1'b1, 8'h11);
    cyc(1'b0, 1'b0, 8'h00); exp_out("rs7", 1'b1, 8'h11, 1'b1, 8'h12);

    // PC wrap at 0xFF
    do_reset(0, "");
    cyc(1'b0, 1'b1, 8'hFE); exp_out("wr0", 1'b0, 8'h00, 1'b1, 8'hFE);
    cyc(1'b0, 1'b0, 8'h00); exp_out("wr1", 1'b1, 8'hFE, 1'b1, 8'hFF);
    cyc(1'b0, 1'b0, 8'h00); exp_out("wr2", 1'b1, 8'hFF, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00); exp_out("wr3", 1'b1, 8'h00, 1'b1, 8'h01);

    // asynchronous reset in the middle of a flush
    do_reset(0, "");
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00); exp_out("ar0", 1'b1, 8'h02, 1'b1, 8'h03);
    mem_lat = 2;
    cyc(1'b0, 1'b1, 8'h40); exp_out("ar1", 1'b0, 8'h00, 1'b1, 8'h03);
    do_reset(1, "ar_rst");
    mem_lat = 0;
    cyc(1'b0, 1'b0, 8'h00); exp_out("ar2", 1'b1, 8'h00, 1'b1, 8'h01);

    // randomized run against the consumed-stream scoreboard
    data_mode = 1;
    lat_rand = 1;
    do_reset(0, "");
    sb_exp = 8'h00;
    n_cons = 0;
    sb_en = 1;
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0, 8'($urandom));
    end
    sb_en = 0;
    chk("rand.progress", n_cons >= 300, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
